vga_sync_decoder: RTL

Recovers pixel coordinates and lock status from a 640x480 VGA sync stream: active-low hsync/vsync plus an activevideo qualifier, sampled once per pixel tick. It is the receive side of the VGA timing generator. It feeds loopback self-check and capture logic that needs (x, y) from sync signals alone. It measures line and frame geometry, and asserts `locked` only after one complete frame matches the nominal timing.

---
 rtl/vga_sync_decoder.sv | 220 ++++++++++++++++++++++
 1 files changed

// File: rtl/vga_sync_decoder.sv
// Receive side of the VGA timing generator: recovers (x, y) from hsync/vsync/activevideo,
// measures line and frame geometry, and reports lock once a full frame matches nominal timing.
module vga_sync_decoder #(
    parameter int WHOLE_LINE  = 800,
    parameter int WHOLE_FRAME = 525,
    parameter int H_VISIBLE   = 640,
    parameter int V_VISIBLE   = 480,
    parameter int XBITS       = 10,
    parameter int YBITS       = 10
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             pix_en,
    input  logic             hsync,
    input  logic             vsync,
    input  logic             activevideo,
    output logic [XBITS-1:0] x,
    output logic [YBITS-1:0] y,
    output logic             pixel_valid,
    output logic             frame_start,
    output logic             locked,
    output logic [11:0]      line_len,
    output logic [11:0]      frame_len,
    output logic [7:0]       err_count
);

    typedef enum logic [1:0] {
        ST_SEARCH = 2'd0,
        ST_VERIFY = 2'd1,
        ST_LOCKED = 2'd2
    } state_t;

    localparam logic [11:0]      LINE_L  = 12'(WHOLE_LINE);
    localparam logic [11:0]      FRAME_L = 12'(WHOLE_FRAME);
    localparam logic [11:0]      HVIS_L  = 12'(H_VISIBLE);
    localparam logic [11:0]      VVIS_L  = 12'(V_VISIBLE);
    localparam logic [11:0]      CNT_MAX = 12'hFFF;
    localparam logic [XBITS-1:0] X_MAX   = {XBITS{1'b1}};
    localparam logic [YBITS-1:0] Y_MAX   = {YBITS{1'b1}};

    state_t           state_r, state_next_s;
    logic             hs_q_r, vs_q_r, av_q_r;
    logic             hfall_s, vfall_s, avrise_s, avfall_s;
    logic [11:0]      hcnt_r, vcnt_r, acnt_r, lcnt_r;
    logic [11:0]      hcnt_inc_s, frame_meas_s;
    logic             hcnt_sat_s, line_bad_s, run_bad_s, frame_bad_s, mismatch_s;
    logic             h_armed_r, frame_good_r, frame_pending_r;
    logic             err_inc_s, pix_valid_next_s, enter_search_s, frame_open_s;
    logic [XBITS-1:0] x_r;
    logic [YBITS-1:0] y_r;
    logic             pixel_valid_r, frame_start_r, locked_r;
    logic [11:0]      line_len_r, frame_len_r;
    logic [7:0]       err_count_r;

    // Sync edges, qualified by the pixel tick so every event below is tick-aligned
    always_comb begin
        hfall_s  = pix_en & hs_q_r & ~hsync;
        vfall_s  = pix_en & vs_q_r & ~vsync;
        avrise_s = pix_en & ~av_q_r & activevideo;
        avfall_s = pix_en & av_q_r & ~activevideo;
    end

    // Geometry checks; a simultaneous hfall belongs to the frame that vfall closes
    always_comb begin
        hcnt_inc_s   = hcnt_r + 12'd1;
        frame_meas_s = (vcnt_r == CNT_MAX) ? CNT_MAX : (vcnt_r + {11'd0, hfall_s});
        hcnt_sat_s   = pix_en & (hcnt_r == CNT_MAX);
        line_bad_s   = hfall_s & h_armed_r & (hcnt_inc_s != LINE_L);
        run_bad_s    = avfall_s & (acnt_r != HVIS_L);
        frame_bad_s  = vfall_s & ((frame_meas_s != FRAME_L) | (lcnt_r != VVIS_L));
        mismatch_s   = line_bad_s | run_bad_s | hcnt_sat_s | frame_bad_s;
    end

    // Lock state register
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_r <= ST_SEARCH;
        end else begin
            state_r <= state_next_s;
        end
    end

    // Lock next-state logic
    always_comb begin
        state_next_s = state_r;
        case (state_r)
            ST_SEARCH: begin
                if (vfall_s) state_next_s = ST_VERIFY;
                else         state_next_s = ST_SEARCH;
            end
            ST_VERIFY: begin
                if (hcnt_sat_s)                                  state_next_s = ST_SEARCH;
                else if (vfall_s & frame_good_r & ~mismatch_s)   state_next_s = ST_LOCKED;
                else                                             state_next_s = ST_VERIFY;
            end
            ST_LOCKED: begin
                if (mismatch_s) state_next_s = ST_SEARCH;
                else            state_next_s = ST_LOCKED;
            end
            default: state_next_s = ST_SEARCH;
        endcase
    end

    // Lock-derived controls; pixel_valid follows the state being registered this tick
    always_comb begin
        err_inc_s        = (state_r == ST_LOCKED) & mismatch_s & (err_count_r != 8'hFF);
        pix_valid_next_s = activevideo & (state_next_s == ST_LOCKED);
        enter_search_s   = (state_r != ST_SEARCH) & (state_next_s == ST_SEARCH);
        frame_open_s     = frame_pending_r | vfall_s;
    end

    // Edge history and line/frame/run measurement counters
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            hs_q_r      <= 1'b1;
            vs_q_r      <= 1'b1;
            av_q_r      <= 1'b0;
            hcnt_r      <= 12'd0;
            vcnt_r      <= 12'd0;
            acnt_r      <= 12'd0;
            lcnt_r      <= 12'd0;
            line_len_r  <= 12'd0;
            frame_len_r <= 12'd0;
            h_armed_r   <= 1'b0;
        end else if (pix_en) begin
            hs_q_r <= hsync;
            vs_q_r <= vsync;
            av_q_r <= activevideo;
            if (hfall_s) begin
                line_len_r <= hcnt_inc_s;
                hcnt_r     <= 12'd0;
            end else if (hcnt_r != CNT_MAX) begin
                hcnt_r <= hcnt_inc_s;
            end
            if (vfall_s) begin
                frame_len_r <= frame_meas_s;
                vcnt_r      <= 12'd0;
            end else if (hfall_s && (vcnt_r != CNT_MAX)) begin
                vcnt_r <= vcnt_r + 12'd1;
            end
            if (avrise_s) begin
                acnt_r <= 12'd1;
            end else if (activevideo && (acnt_r != CNT_MAX)) begin
                acnt_r <= acnt_r + 12'd1;
            end
            if (vfall_s) begin
                lcnt_r <= {11'd0, avrise_s};
            end else if (avrise_s && (lcnt_r != CNT_MAX)) begin
                lcnt_r <= lcnt_r + 12'd1;
            end
            // The first hfall after (re)entering SEARCH only restarts the period count
            if (enter_search_s) begin
                h_armed_r <= 1'b0;
            end else if (hfall_s) begin
                h_armed_r <= 1'b1;
            end
        end
    end

    // Verify-frame flag, lock output and lock-loss counter
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            frame_good_r <= 1'b0;
            locked_r     <= 1'b0;
            err_count_r  <= 8'd0;
        end else if (pix_en) begin
            locked_r <= (state_next_s == ST_LOCKED);
            if ((state_r == ST_SEARCH) && vfall_s) begin
                frame_good_r <= 1'b1;
            end else if ((state_r == ST_VERIFY) && vfall_s) begin
                frame_good_r <= 1'b1;
            end else if ((state_r == ST_VERIFY) && mismatch_s) begin
                frame_good_r <= 1'b0;
            end
            if (err_inc_s) begin
                err_count_r <= err_count_r + 8'd1;
            end
        end
    end

    // Coordinate recovery; frame_start is a single-clk pulse even between ticks
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            x_r             <= {XBITS{1'b0}};
            y_r             <= {YBITS{1'b0}};
            frame_pending_r <= 1'b0;
            frame_start_r   <= 1'b0;
            pixel_valid_r   <= 1'b0;
        end else begin
            frame_start_r <= avrise_s & frame_open_s;
            if (pix_en) begin
                pixel_valid_r <= pix_valid_next_s;
                if (avrise_s) begin
                    x_r <= {XBITS{1'b0}};
                end else if (activevideo && (x_r != X_MAX)) begin
                    x_r <= x_r + XBITS'(1);
                end
                if (avrise_s && frame_open_s) begin
                    y_r             <= {YBITS{1'b0}};
                    frame_pending_r <= 1'b0;
                end else begin
                    frame_pending_r <= frame_open_s;
                    if (avrise_s && (y_r != Y_MAX)) begin
                        y_r <= y_r + YBITS'(1);
                    end
                end
            end
        end
    end

    assign x           = x_r;
    assign y           = y_r;
    assign pixel_valid = pixel_valid_r;
    assign frame_start = frame_start_r;
    assign locked      = locked_r;
    assign line_len    = line_len_r;
    assign frame_len   = frame_len_r;
    assign err_count   = err_count_r;

endmodule
